fp_div_seq: RTL
===============

# fp_div_seq

IEEE-754 single-precision divide sequencer wrapped around the `goldschmidtVersion2` 32-bit integer divider. It unpacks both operands and resolves special cases without using the divider. For normal operands it drives the divider through four chained integer-divide passes to build a 33-bit mantissa quotient, then normalises, rounds (round-to-nearest-even) and packs the result. It is the FPU-facing front end of the divide path: it feeds the divider and consumes its quotient and remainder.

## Interface
- `DIV_TIMEOUT`, default 255: maximum cycles spent in WAIT per pass before the operation is aborted.
- `clk`  in  1  clock; all state updates on the rising edge.
- `clrn`  in  1  reset, synchronous, active-high.
- `a`  in  32  dividend, IEEE single; sampled when `start` is accepted.
- `b`  in  32  divisor, IEEE single; sampled when `start` is accepted.
- `start`  in  1  request; accepted only in IDLE.
- `result`  out  32  packed quotient; held until the next accepted `start`.
- `flags`  out  5  {invalid, divzero, overflow, underflow, inexact}; held with `result`.
- `err`  out  1  divider timeout occurred; held with `result`.
- `busy`  out  1  high from the cycle after acceptance until `ready`.
- `ready`  out  1  one-cycle pulse; `result`, `flags` and `err` are valid.
- `div_dividend`  out  32  divider dividend; held stable from ISSUE through capture.
- `div_divisor`  out  32  divider divisor; held stable from ISSUE through capture.
- `div_start`  out  1  one-cycle launch pulse to the divider.
- `div_quotient`  in  32  divider quotient.
- `div_rem`  in  32  divider remainder.
- `div_busy`  in  1  divider busy.
- `div_ready`  in  1  divider done.

## Operation
- States: IDLE, UNPACK, ISSUE, WAIT, NORM, ROUND, DONE.
- IDLE + `start` → UNPACK: latch `a` and `b`; clear `flags` and `err`.
- UNPACK:
  - Denormal inputs are flushed to signed zero.
  - sign = sa ^ sb.
  - Specials go straight to DONE:
    - any NaN → 7FC00000, invalid.
    - 0/0 or inf/inf → 7FC00000, invalid.
    - finite/0 → signed inf, divzero.
    - 0/finite or finite/inf → signed zero.
    - inf/finite → signed inf.
  - Otherwise: ma and mb = {1, frac} (24 bits); exp = ea − eb + 127 (signed 10-bit); r = ma; pass = 0. Go to ISSUE.
- ISSUE, taken only when `div_busy` = 0:
  - Drive `div_dividend` = r<<8 (pass 0: ma<<8) and `div_divisor` = mb.
  - Pulse `div_start` for exactly one cycle, then go to WAIT.
- WAIT:
  - Ignore `div_ready` in the first cycle after ISSUE, because a stale ready can persist from the previous pass.
  - On `div_ready`: Q = (Q<<8) | `div_quotient` (pass 0 loads directly); r = `div_rem`; pass++.
  - pass < 4 → ISSUE; pass = 4 → NORM.
  - Timeout counter reaches `DIV_TIMEOUT` → DONE with result 7FC00000, invalid = 1, `err` = 1.
- Arithmetic:
  - Q = floor(ma·2^32 / mb) ∈ [2^31, 2^33).
  - Final r < mb < 2^24, so r<<8 always fits in 32 bits.
- NORM:
  - Q[32] = 1: mant = Q[32:9], guard = Q[8], sticky = |Q[7:0] | (r≠0).
  - Q[32] = 0: mant = Q[31:8], guard = Q[7], sticky = |Q[6:0] | (r≠0); exp −= 1.
- ROUND:
  - RNE: increment mant when guard & (sticky | mant[0]).
  - Mantissa carry-out → mant = 800000, exp += 1.
  - inexact = guard | sticky.
  - exp ≥ 255 → signed inf, overflow + inexact.
  - exp ≤ 0 → signed zero, underflow + inexact (no subnormal output).
- DONE: `ready` = 1 for one cycle → IDLE.
- `start` while `busy` is ignored.
- `start` in the same cycle as DONE is ignored; it is accepted from IDLE one cycle later.

## Timing
- Reset: state IDLE; `result`, `flags`, `err`, `busy`, `ready`, `div_start`, `div_dividend`, `div_divisor` all 0. Counters and Q cleared.
- Reset mid-operation: abort in the same edge with the outputs above. The divider is reset by its own `clrn` and is not driven further.
- Special case: `start` sampled at cycle 0 → `ready` at cycle 2.
- Normal case, with L = cycles from `div_start` to `div_ready` (L ≥ 2) and `div_busy` low at each ISSUE:
  - First ISSUE at cycle 2.
  - Each pass takes L+1 cycles.
  - `ready` at cycle 8+4L.
- `busy` is high cycles 1 … (ready−1) and low in the `ready` cycle.

## Test plan
- 6.0 / 2.0 (a = 40C00000, b = 40000000) → result 40400000, flags 0, Q[32] = 1 path, exactly four `div_start` pulses.
- 1.0 / 3.0 (3F800000, 3EAAAAAB check) → Q = 0AAAAAAAA, Q[32] = 0 path, round-up, result 3EAAAAAB, inexact = 1.
- 1.0 / 0.0 → 7F800000, divzero = 1, `ready` at cycle 2, `div_start` never asserted.
- 0.0 / 0.0 and 7F800000 / FF800000 → 7FC00000, invalid = 1. 7FC00001 / 1.0 → 7FC00000.
- 7F7FFFFF / 00800000 → 7F800000, overflow = 1, inexact = 1.
- Robustness: assert `clrn` during pass 2 WAIT → next cycle all outputs 0, IDLE. Then 1.0/3.0 completes as above. Hold `div_ready` low → after `DIV_TIMEOUT` cycles, `ready` with 7FC00000, `err` = 1.

Source files
------------

// File: rtl/fp_div_seq.sv
// fp_div_seq: IEEE-754 single-precision divide sequencer; runs four 8-bit integer-divide passes
// on an external divider, then normalises, rounds to nearest-even and packs the quotient.
module fp_div_seq #(
    parameter int DIV_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic [31:0] result,
    output logic [4:0]  flags,
    output logic        err,
    output logic        busy,
    output logic        ready,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_start,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_rem,
    input  logic        div_busy,
    input  logic        div_ready
);
    localparam int CW = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(DIV_TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC00000;
    typedef enum logic [2:0] {IDLE, UNPACK, ISSUE, WAIT, NORM, ROUND, DONE} state_t;
    state_t state, state_n;
    logic [31:0] ra, rb;
    logic [32:0] q;
    logic [31:0] r;
    logic [2:0] pass;
    logic [CW-1:0] cnt;
    logic signed [9:0] ex;
    logic [23:0] mant;
    logic guard, sticky;
    logic [7:0] ea, eb;
    logic za, zb, ia, ib, invalid, special, sign, cap, hi;
    logic [31:0] spec_res, round_res;
    logic [4:0] spec_flags, round_flags;
    logic [24:0] sum;
    logic signed [9:0] ex_r;
    logic ovf, unf;
    assign ea = ra[30:23];
    assign eb = rb[30:23];
    assign sign = ra[31] ^ rb[31];
    // A zero exponent covers denormals too, which are flushed to signed zero.
    assign za = ea == 8'd0;
    assign zb = eb == 8'd0;
    assign ia = ea == 8'hFF && ra[22:0] == 23'd0;
    assign ib = eb == 8'hFF && rb[22:0] == 23'd0;
    assign invalid = (ea == 8'hFF && ra[22:0] != 23'd0) || (eb == 8'hFF && rb[22:0] != 23'd0)
                     || (za && zb) || (ia && ib);
    assign special = invalid || ia || ib || za || zb;
    assign spec_res = invalid ? QNAN : (ia || zb) ? {sign, 8'hFF, 23'd0} : {sign, 31'd0};
    assign spec_flags = {invalid, !invalid && !ia && zb, 3'b000};
    // The first WAIT cycle may still see the previous pass's ready, so it is never captured.
    assign cap = state == WAIT && div_ready && cnt != '0;
    assign hi = q[32];
    assign sum = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    assign ex_r = ex + (sum[24] ? 10'sd1 : 10'sd0);
    assign ovf = ex_r >= 10'sd255;
    assign unf = ex_r <= 10'sd0;
    assign round_res = ovf ? {sign, 8'hFF, 23'd0} : unf ? {sign, 31'd0}
                       : {sign, ex_r[7:0], sum[24] ? 23'd0 : sum[22:0]};
    assign round_flags = {2'b00, ovf, unf && !ovf, guard | sticky | ovf | unf};
    assign ready = state == DONE;
    assign busy = state != IDLE && state != DONE;
    always_comb begin
        state_n = state;
        div_start = 1'b0;
        case (state)
            IDLE:    state_n = start ? UNPACK : IDLE;
            UNPACK:  state_n = special ? DONE : ISSUE;
            ISSUE: begin
                div_start = !div_busy;
                state_n = div_busy ? ISSUE : WAIT;
            end
            WAIT:    state_n = cap ? (pass == 3'd3 ? NORM : ISSUE) : (cnt == TMO ? DONE : WAIT);
            NORM:    state_n = ROUND;
            ROUND:   state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (clrn) begin
            state <= IDLE;
            result <= '0;
            flags <= '0;
            err <= 1'b0;
            div_dividend <= '0;
            div_divisor <= '0;
            ra <= '0;
            rb <= '0;
            q <= '0;
            r <= '0;
            pass <= '0;
            cnt <= '0;
            ex <= '0;
            mant <= '0;
            guard <= 1'b0;
            sticky <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    ra <= a;
                    rb <= b;
                    flags <= '0;
                    err <= 1'b0;
                end
                UNPACK: if (special) begin
                    result <= spec_res;
                    flags <= spec_flags;
                end else begin
                    ex <= signed'({2'b00, ea}) - signed'({2'b00, eb}) + 10'sd127;
                    div_dividend <= {1'b1, ra[22:0], 8'd0};
                    div_divisor <= {8'd0, 1'b1, rb[22:0]};
                    pass <= '0;
                end
                ISSUE: cnt <= '0;
                WAIT: if (cap) begin
                    q <= (pass == 3'd0 ? 33'd0 : q << 8) | {1'b0, div_quotient};
                    r <= div_rem;
                    pass <= pass + 3'd1;
                    div_dividend <= {div_rem[23:0], 8'd0};
                end else if (cnt == TMO) begin
                    result <= QNAN;
                    flags <= 5'b10000;
                    err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                NORM: begin
                    mant <= hi ? q[32:9] : q[31:8];
                    guard <= hi ? q[8] : q[7];
                    sticky <= (hi ? |q[7:0] : |q[6:0]) | (r != 32'd0);
                    ex <= hi ? ex : ex - 10'sd1;
                end
                ROUND: begin
                    result <= round_res;
                    flags <= round_flags;
                end
                default: ;
            endcase
        end
    end
endmodule
